dmem_arbiter: RTL and testbench

Single-port data-memory arbiter and sequencer for the out-of-order core. It shares one data-memory port between the load unit (speculative loads) and the store commit path (retired stores). It also runs the request/grant/response sequence with the memory and performs byte-lane steering and sign or zero extension using the decoder's `load_size` encoding. It sits between the load/store execution logic and the data memory or cache interface, with one outstanding memory transaction at a time.

---
 rtl/dmem_arbiter.sv | 326 ++++++++++++++++++++++++++++++++
 tb/tb_dmem_arbiter.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
// Shares one data-memory port between speculative loads and retired stores.
// Runs the req/gnt/rvalid sequence with one transaction outstanding, steers
// store bytes onto lanes, and selects/extends load data by size and offset.
//
// Optional feature macro: DMEM_ARB_MISALIGN_CHK_EN
//   When defined, misaligned halves/words complete immediately with an error
//   flag and are never issued. When undefined, the error outputs are tied 0.
//
// Ports
//   clk, rst_n            clock, async active-low reset
//   flush                 squash in-flight / pending loads (stores unaffected)
//   ld_valid/ld_ready     load request handshake (ld_addr, ld_size, ld_tag)
//   ld_resp_*             registered single-cycle load completion
//   st_valid/st_ready     store request handshake (st_addr, st_data, st_size)
//   st_done, st_err       registered single-cycle store completion
//   mem_req..mem_be       registered memory request, held until mem_gnt
//   mem_gnt               memory accepts the request
//   mem_rvalid, mem_rdata read data return
// -----------------------------------------------------------------------------
module dmem_arbiter #(
    parameter int TAG_W        = 4,
    parameter int STARVE_LIMIT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             ld_valid,
    output logic             ld_ready,
    input  logic [31:0]      ld_addr,
    input  logic [2:0]       ld_size,
    input  logic [TAG_W-1:0] ld_tag,
    output logic             ld_resp_valid,
    output logic [31:0]      ld_resp_data,
    output logic [TAG_W-1:0] ld_resp_tag,
    output logic             ld_resp_err,
    input  logic             st_valid,
    output logic             st_ready,
    input  logic [31:0]      st_addr,
    input  logic [31:0]      st_data,
    input  logic [1:0]       st_size,
    output logic             st_done,
    output logic             st_err,
    output logic             mem_req,
    output logic             mem_we,
    output logic [31:0]      mem_addr,
    output logic [31:0]      mem_wdata,
    output logic [3:0]       mem_be,
    input  logic             mem_gnt,
    input  logic             mem_rvalid,
    input  logic [31:0]      mem_rdata
);

    localparam int               CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);
    localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_RESP = 2'd2
    } state_t;

    // Lane select and extension of returned read data. A half at offset 3
    // only has byte 3 available, so it behaves like a byte access.
    function automatic logic [31:0] ld_extend(input logic [31:0] rdata,
                                              input logic [1:0]  off,
                                              input logic [2:0]  size);
        logic [31:0] sh;
        logic [31:0] res;
        sh = rdata >> {off, 3'b000};
        case (size[1:0])
            2'b00: res = size[2] ? {{24{sh[7]}}, sh[7:0]} : {24'h000000, sh[7:0]};
            2'b01: begin
                if (off == 2'd3) begin
                    res = size[2] ? {{24{sh[7]}}, sh[7:0]} : {24'h000000, sh[7:0]};
                end else begin
                    res = size[2] ? {{16{sh[15]}}, sh[15:0]} : {16'h0000, sh[15:0]};
                end
            end
            default: res = rdata;
        endcase
        return res;
    endfunction

`ifdef DMEM_ARB_MISALIGN_CHK_EN
    function automatic logic is_misaligned(input logic [1:0] sz, input logic [1:0] off);
        return ((sz == 2'b01) && off[0]) || (sz[1] && (off != 2'b00));
    endfunction
`endif

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_starve;
    logic             r_is_load;
    logic [1:0]       r_off;
    logic [2:0]       r_size;
    logic [TAG_W-1:0] r_tag;
    logic             r_kill;
    logic             r_mem_req;
    logic             r_mem_we;
    logic [31:0]      r_mem_addr;
    logic [31:0]      r_mem_wdata;
    logic [3:0]       r_mem_be;
    logic             r_ld_resp_valid;
    logic [31:0]      r_ld_resp_data;
    logic [TAG_W-1:0] r_ld_resp_tag;
    logic             r_st_done;

    logic             w_idle;
    logic             w_ld_cand;
    logic             w_ld_win;
    logic             w_ld_acc;
    logic             w_st_acc;
    logic             w_ld_mis;
    logic             w_st_mis;
    logic [3:0]       w_st_be;
    logic [31:0]      w_st_wdata;

    // A flushed load is not a candidate, so a waiting store can still go.
    assign w_idle    = (r_state == S_IDLE);
    assign w_ld_cand = ld_valid && !flush;
    assign w_ld_win  = w_ld_cand && (!st_valid || (r_starve == LIMIT));
    assign ld_ready  = w_idle && w_ld_win;
    assign st_ready  = w_idle && st_valid && !w_ld_win;
    assign w_ld_acc  = ld_valid && ld_ready;
    assign w_st_acc  = st_valid && st_ready;

`ifdef DMEM_ARB_MISALIGN_CHK_EN
    logic r_ld_resp_err;
    logic r_st_err;
    assign w_ld_mis    = is_misaligned(ld_size[1:0], ld_addr[1:0]);
    assign w_st_mis    = is_misaligned(st_size, st_addr[1:0]);
    assign ld_resp_err = r_ld_resp_err;
    assign st_err      = r_st_err;
`else
    assign w_ld_mis    = 1'b0;
    assign w_st_mis    = 1'b0;
    assign ld_resp_err = 1'b0;
    assign st_err      = 1'b0;
`endif

    // Store byte enables and lane-replicated write data.
    always_comb begin
        w_st_be    = 4'b1111;
        w_st_wdata = st_data;
        case (st_size)
            2'b00: begin
                w_st_be    = 4'b0001 << st_addr[1:0];
                w_st_wdata = {4{st_data[7:0]}};
            end
            2'b01: begin
                w_st_be    = 4'b0011 << st_addr[1:0];
                w_st_wdata = {2{st_data[15:0]}};
            end
            default: begin
                w_st_be    = 4'b1111;
                w_st_wdata = st_data;
            end
        endcase
    end

    // Next-state logic of the request sequencer.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_ld_acc && !w_ld_mis) begin
                    w_state_nxt = S_REQ;
                end else if (w_st_acc && !w_st_mis) begin
                    w_state_nxt = S_REQ;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_REQ: begin
                // A grant beats a simultaneous flush; the kill flag handles it.
                if (mem_gnt) begin
                    w_state_nxt = r_is_load ? S_RESP : S_IDLE;
                end else if (flush && r_is_load) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_state_nxt = S_REQ;
                end
            end
            S_RESP: begin
                if (mem_rvalid) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_state_nxt = S_RESP;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Request capture, memory request, completion pulses and starve counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_starve        <= '0;
            r_is_load       <= 1'b0;
            r_off           <= 2'b00;
            r_size          <= 3'b000;
            r_tag           <= '0;
            r_kill          <= 1'b0;
            r_mem_req       <= 1'b0;
            r_mem_we        <= 1'b0;
            r_mem_addr      <= 32'h0000_0000;
            r_mem_wdata     <= 32'h0000_0000;
            r_mem_be        <= 4'b0000;
            r_ld_resp_valid <= 1'b0;
            r_ld_resp_data  <= 32'h0000_0000;
            r_ld_resp_tag   <= '0;
            r_st_done       <= 1'b0;
`ifdef DMEM_ARB_MISALIGN_CHK_EN
            r_ld_resp_err   <= 1'b0;
            r_st_err        <= 1'b0;
`endif
        end else begin
            r_ld_resp_valid <= 1'b0;
            r_st_done       <= 1'b0;
`ifdef DMEM_ARB_MISALIGN_CHK_EN
            r_ld_resp_err   <= 1'b0;
            r_st_err        <= 1'b0;
`endif
            case (r_state)
                S_IDLE: begin
                    if (w_ld_acc) begin
                        r_is_load <= 1'b1;
                        r_off     <= ld_addr[1:0];
                        r_size    <= ld_size;
                        r_tag     <= ld_tag;
                        r_starve  <= '0;
                        r_kill    <= 1'b0;
                        if (w_ld_mis) begin
                            r_ld_resp_valid <= 1'b1;
                            r_ld_resp_data  <= 32'h0000_0000;
                            r_ld_resp_tag   <= ld_tag;
`ifdef DMEM_ARB_MISALIGN_CHK_EN
                            r_ld_resp_err   <= 1'b1;
`endif
                        end else begin
                            r_mem_req   <= 1'b1;
                            r_mem_we    <= 1'b0;
                            r_mem_addr  <= {ld_addr[31:2], 2'b00};
                            r_mem_be    <= 4'b1111;
                            r_mem_wdata <= 32'h0000_0000;
                        end
                    end else if (w_st_acc) begin
                        r_is_load <= 1'b0;
                        if (ld_valid && (r_starve != LIMIT)) begin
                            r_starve <= r_starve + ONE;
                        end
                        if (w_st_mis) begin
                            r_st_done <= 1'b1;
`ifdef DMEM_ARB_MISALIGN_CHK_EN
                            r_st_err  <= 1'b1;
`endif
                        end else begin
                            r_mem_req   <= 1'b1;
                            r_mem_we    <= 1'b1;
                            r_mem_addr  <= {st_addr[31:2], 2'b00};
                            r_mem_be    <= w_st_be;
                            r_mem_wdata <= w_st_wdata;
                        end
                    end else begin
                        r_mem_req <= 1'b0;
                    end
                end
                S_REQ: begin
                    if (mem_gnt) begin
                        r_mem_req <= 1'b0;
                        if (!r_is_load) begin
                            r_st_done <= 1'b1;
                        end else if (flush) begin
                            r_kill <= 1'b1;
                        end
                    end else if (flush && r_is_load) begin
                        r_mem_req <= 1'b0;
                    end else begin
                        r_mem_req <= 1'b1;
                    end
                end
                S_RESP: begin
                    if (mem_rvalid) begin
                        if (!r_kill && !flush) begin
                            r_ld_resp_valid <= 1'b1;
                            r_ld_resp_data  <= ld_extend(mem_rdata, r_off, r_size);
                            r_ld_resp_tag   <= r_tag;
                        end
                        r_kill <= 1'b0;
                    end else if (flush) begin
                        r_kill <= 1'b1;
                    end else begin
                        r_kill <= r_kill;
                    end
                end
                default: begin
                    r_mem_req <= 1'b0;
                    r_kill    <= 1'b0;
                end
            endcase
        end
    end

    assign mem_req       = r_mem_req;
    assign mem_we        = r_mem_we;
    assign mem_addr      = r_mem_addr;
    assign mem_wdata     = r_mem_wdata;
    assign mem_be        = r_mem_be;
    assign ld_resp_valid = r_ld_resp_valid;
    assign ld_resp_data  = r_ld_resp_data;
    assign ld_resp_tag   = r_ld_resp_tag;
    assign st_done       = r_st_done;

endmodule

// File: tb/tb_dmem_arbiter.sv
module tb_dmem_arbiter;
    localparam int TAG_W = 4;

    logic             clk;
    logic             rst_n;
    logic             flush;
    logic             ld_valid;
    logic             ld_ready;
    logic [31:0]      ld_addr;
    logic [2:0]       ld_size;
    logic [TAG_W-1:0] ld_tag;
    logic             ld_resp_valid;
    logic [31:0]      ld_resp_data;
    logic [TAG_W-1:0] ld_resp_tag;
    logic             ld_resp_err;
    logic             st_valid;
    logic             st_ready;
    logic [31:0]      st_addr;
    logic [31:0]      st_data;
    logic [1:0]       st_size;
    logic             st_done;
    logic             st_err;
    logic             mem_req;
    logic             mem_we;
    logic [31:0]      mem_addr;
    logic [31:0]      mem_wdata;
    logic [3:0]       mem_be;
    logic             mem_gnt;
    logic             mem_rvalid;
    logic [31:0]      mem_rdata;

    int n_pass  = 0;
    int n_total = 0;

    dmem_arbiter #(.TAG_W(TAG_W), .STARVE_LIMIT(4)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_addr(ld_addr),
        .ld_size(ld_size), .ld_tag(ld_tag),
        .ld_resp_valid(ld_resp_valid), .ld_resp_data(ld_resp_data),
        .ld_resp_tag(ld_resp_tag), .ld_resp_err(ld_resp_err),
        .st_valid(st_valid), .st_ready(st_ready), .st_addr(st_addr),
        .st_data(st_data), .st_size(st_size), .st_done(st_done), .st_err(st_err),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_gnt(mem_gnt),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset();
        rst_n = 1'b0; flush = 1'b0; ld_valid = 1'b0; ld_addr = 32'h0; ld_size = 3'b000;
        ld_tag = 4'h0; st_valid = 1'b0; st_addr = 32'h0; st_data = 32'h0; st_size = 2'b00;
        mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0;
        repeat (3) @(negedge clk);
        n_total++; if (mem_req !== 1'b0) $display("FAIL rst_mem_req got %b exp 0", mem_req); else n_pass++;
        n_total++; if (mem_be !== 4'h0) $display("FAIL rst_mem_be got %h exp 0", mem_be); else n_pass++;
        n_total++; if (mem_addr !== 32'h0) $display("FAIL rst_mem_addr got %h exp 0", mem_addr); else n_pass++;
        n_total++; if (ld_resp_valid !== 1'b0) $display("FAIL rst_resp_valid got %b exp 0", ld_resp_valid); else n_pass++;
        n_total++; if (st_done !== 1'b0) $display("FAIL rst_st_done got %b exp 0", st_done); else n_pass++;
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_load_byte();
        ld_valid = 1'b1; ld_addr = 32'h104; ld_size = 3'b100; ld_tag = 4'h5; #1;
        n_total++; if (ld_ready !== 1'b1) $display("FAIL lb_ld_ready got %b exp 1", ld_ready); else n_pass++;
        @(negedge clk); ld_valid = 1'b0;
        n_total++; if (mem_req !== 1'b1) $display("FAIL lb_mem_req got %b exp 1", mem_req); else n_pass++;
        n_total++; if (mem_addr !== 32'h104) $display("FAIL lb_mem_addr got %h exp 104", mem_addr); else n_pass++;
        n_total++; if ({mem_we, mem_be} !== 5'b0_1111) $display("FAIL lb_we_be got %b exp 01111", {mem_we, mem_be}); else n_pass++;
        mem_gnt = 1'b1;
        @(negedge clk); mem_gnt = 1'b0;
        n_total++; if (mem_req !== 1'b0) $display("FAIL lb_req_drop got %b exp 0", mem_req); else n_pass++;
        mem_rvalid = 1'b1; mem_rdata = 32'h0000_80FF;
        @(negedge clk); mem_rvalid = 1'b0;
        n_total++; if (ld_resp_valid !== 1'b1) $display("FAIL lb_resp_valid got %b exp 1", ld_resp_valid); else n_pass++;
        n_total++; if (ld_resp_data !== 32'hFFFF_FFFF) $display("FAIL lb_resp_data got %h exp ffffffff", ld_resp_data); else n_pass++;
        n_total++; if (ld_resp_tag !== 4'h5) $display("FAIL lb_resp_tag got %h exp 5", ld_resp_tag); else n_pass++;
        @(negedge clk);
        n_total++; if (ld_resp_valid !== 1'b0) $display("FAIL lb_resp_pulse got %b exp 0", ld_resp_valid); else n_pass++;
    endtask

    task automatic test_load_half();
        ld_valid = 1'b1; ld_addr = 32'h106; ld_size = 3'b001; ld_tag = 4'h3;
        @(negedge clk); ld_valid = 1'b0;
        n_total++; if (mem_addr !== 32'h104) $display("FAIL lh_mem_addr got %h exp 104", mem_addr); else n_pass++;
        n_total++; if (mem_be !== 4'b1111) $display("FAIL lh_mem_be got %b exp 1111", mem_be); else n_pass++;
        @(negedge clk); mem_gnt = 1'b1;
        @(negedge clk); mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h8001_1234;
        @(negedge clk); mem_rvalid = 1'b0;
        n_total++; if (ld_resp_valid !== 1'b1) $display("FAIL lh_resp_valid got %b exp 1", ld_resp_valid); else n_pass++;
        n_total++; if (ld_resp_data !== 32'h0000_8001) $display("FAIL lh_resp_data got %h exp 00008001", ld_resp_data); else n_pass++;
        n_total++; if (ld_resp_tag !== 4'h3) $display("FAIL lh_resp_tag got %h exp 3", ld_resp_tag); else n_pass++;
    endtask

    task automatic test_store_byte();
        @(negedge clk);
        st_valid = 1'b1; st_addr = 32'h203; st_size = 2'b00; st_data = 32'h0000_00AB; #1;
        n_total++; if (st_ready !== 1'b1) $display("FAIL sb_st_ready got %b exp 1", st_ready); else n_pass++;
        @(negedge clk); st_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            n_total++;
            if ({mem_req, mem_we, mem_be, mem_addr, mem_wdata} !== {1'b1, 1'b1, 4'b1000, 32'h200, 32'hABAB_ABAB})
                $display("FAIL sb_hold%0d got req=%b we=%b be=%b addr=%h wd=%h exp 1 1 1000 200 abababab",
                         i, mem_req, mem_we, mem_be, mem_addr, mem_wdata);
            else n_pass++;
            @(negedge clk);
        end
        mem_gnt = 1'b1;
        @(negedge clk); mem_gnt = 1'b0;
        n_total++; if ({st_done, mem_req} !== 2'b10) $display("FAIL sb_done got done=%b req=%b exp 1 0", st_done, mem_req); else n_pass++;
        @(negedge clk);
        n_total++; if (st_done !== 1'b0) $display("FAIL sb_done_pulse got %b exp 0", st_done); else n_pass++;
    endtask

    task automatic test_starve();
        int n_st;
        bit got_ld;
        n_st = 0; got_ld = 1'b0;
        mem_gnt = 1'b1;
        ld_valid = 1'b1; ld_addr = 32'h500; ld_size = 3'b010; ld_tag = 4'h9;
        st_valid = 1'b1; st_addr = 32'h600; st_size = 2'b10; st_data = 32'h1111_2222;
        for (int i = 0; i < 40 && !got_ld; i++) begin
            #1;
            if (ld_ready) got_ld = 1'b1;
            else if (st_ready) n_st++;
            @(negedge clk);
        end
        ld_valid = 1'b0; st_valid = 1'b0;
        n_total++; if (got_ld !== 1'b1) $display("FAIL stv_load_timeout got %b exp 1", got_ld); else n_pass++;
        n_total++; if (n_st != 4) $display("FAIL stv_store_count got %0d exp 4", n_st); else n_pass++;
        n_total++; if ({mem_req, mem_we} !== 2'b10) $display("FAIL stv_ld_req got req=%b we=%b exp 1 0", mem_req, mem_we); else n_pass++;
        @(negedge clk); mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'hCAFE_BABE;
        @(negedge clk); mem_rvalid = 1'b0;
        n_total++; if ({ld_resp_valid, ld_resp_tag, ld_resp_data} !== {1'b1, 4'h9, 32'hCAFE_BABE})
            $display("FAIL stv_resp got v=%b tag=%h d=%h exp 1 9 cafebabe", ld_resp_valid, ld_resp_tag, ld_resp_data); else n_pass++;
        ld_valid = 1'b1; st_valid = 1'b1; #1;
        n_total++; if ({st_ready, ld_ready} !== 2'b10) $display("FAIL stv_cnt_clear got st=%b ld=%b exp 1 0", st_ready, ld_ready); else n_pass++;
        ld_valid = 1'b0; st_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_flush_resp();
        ld_valid = 1'b1; ld_addr = 32'h300; ld_size = 3'b010; ld_tag = 4'h7;
        @(negedge clk); ld_valid = 1'b0; mem_gnt = 1'b1;
        @(negedge clk); mem_gnt = 1'b0; flush = 1'b1;
        @(negedge clk); flush = 1'b0;
        n_total++; if (ld_resp_valid !== 1'b0) $display("FAIL fr_resp_t3 got %b exp 0", ld_resp_valid); else n_pass++;
        @(negedge clk); mem_rvalid = 1'b1; mem_rdata = 32'h1234_5678;
        @(negedge clk); mem_rvalid = 1'b0;
        n_total++; if (ld_resp_valid !== 1'b0) $display("FAIL fr_resp_suppr got %b exp 0", ld_resp_valid); else n_pass++;
        st_valid = 1'b1; st_addr = 32'h400; st_size = 2'b01; st_data = 32'h0000_1234; #1;
        n_total++; if (st_ready !== 1'b1) $display("FAIL fr_idle_st_ready got %b exp 1", st_ready); else n_pass++;
        @(negedge clk); st_valid = 1'b0;
        n_total++; if ({mem_req, mem_we, mem_be, mem_wdata} !== {1'b1, 1'b1, 4'b0011, 32'h1234_1234})
            $display("FAIL fr_store_req got req=%b we=%b be=%b wd=%h exp 1 1 0011 12341234", mem_req, mem_we, mem_be, mem_wdata); else n_pass++;
        n_total++; if (ld_resp_valid !== 1'b0) $display("FAIL fr_resp_late got %b exp 0", ld_resp_valid); else n_pass++;
        mem_gnt = 1'b1;
        @(negedge clk); mem_gnt = 1'b0;
        n_total++; if (st_done !== 1'b1) $display("FAIL fr_st_done got %b exp 1", st_done); else n_pass++;
    endtask

    task automatic test_flush_req();
        flush = 1'b1; ld_valid = 1'b1; ld_addr = 32'h310; ld_size = 3'b010; ld_tag = 4'h2; #1;
        n_total++; if (ld_ready !== 1'b0) $display("FAIL fq_ready_flush got %b exp 0", ld_ready); else n_pass++;
        @(negedge clk); flush = 1'b0;
        n_total++; if (mem_req !== 1'b0) $display("FAIL fq_no_accept got %b exp 0", mem_req); else n_pass++;
        @(negedge clk); ld_valid = 1'b0;
        n_total++; if (mem_req !== 1'b1) $display("FAIL fq_req got %b exp 1", mem_req); else n_pass++;
        flush = 1'b1;
        @(negedge clk); flush = 1'b0;
        n_total++; if (mem_req !== 1'b0) $display("FAIL fq_req_drop got %b exp 0", mem_req); else n_pass++;
        ld_valid = 1'b1; ld_addr = 32'h320; ld_tag = 4'h4; #1;
        n_total++; if (ld_ready !== 1'b1) $display("FAIL fq_back_idle got %b exp 1", ld_ready); else n_pass++;
        @(negedge clk); ld_valid = 1'b0; flush = 1'b1; mem_gnt = 1'b1;
        @(negedge clk); flush = 1'b0; mem_gnt = 1'b0;
        n_total++; if (mem_req !== 1'b0) $display("FAIL fq_gnt_flush_req got %b exp 0", mem_req); else n_pass++;
        mem_rvalid = 1'b1; mem_rdata = 32'h5555_AAAA;
        @(negedge clk); mem_rvalid = 1'b0;
        n_total++; if (ld_resp_valid !== 1'b0) $display("FAIL fq_gnt_flush_resp got %b exp 0", ld_resp_valid); else n_pass++;
    endtask

    task automatic test_rvalid_ignored();
        mem_rvalid = 1'b1; mem_rdata = 32'h7777_7777;
        @(negedge clk); mem_rvalid = 1'b0;
        n_total++; if (ld_resp_valid !== 1'b0) $display("FAIL rv_idle got %b exp 0", ld_resp_valid); else n_pass++;
    endtask

    task automatic test_misalign();
        ld_valid = 1'b1; ld_addr = 32'h102; ld_size = 3'b010; ld_tag = 4'h6;
        @(negedge clk); ld_valid = 1'b0;
`ifdef DMEM_ARB_MISALIGN_CHK_EN
        n_total++; if ({mem_req, ld_resp_valid, ld_resp_err, ld_resp_data, ld_resp_tag} !== {1'b0, 1'b1, 1'b1, 32'h0, 4'h6})
            $display("FAIL ma_ld got req=%b v=%b err=%b d=%h tag=%h exp 0 1 1 0 6", mem_req, ld_resp_valid, ld_resp_err, ld_resp_data, ld_resp_tag); else n_pass++;
        @(negedge clk);
        n_total++; if ({mem_req, ld_resp_valid} !== 2'b00) $display("FAIL ma_ld_after got req=%b v=%b exp 0 0", mem_req, ld_resp_valid); else n_pass++;
        st_valid = 1'b1; st_addr = 32'h201; st_size = 2'b01; st_data = 32'h0000_BEEF;
        @(negedge clk); st_valid = 1'b0;
        n_total++; if ({mem_req, st_done, st_err} !== 3'b011) $display("FAIL ma_st got req=%b done=%b err=%b exp 0 1 1", mem_req, st_done, st_err); else n_pass++;
`else
        n_total++; if ({mem_req, mem_addr, mem_be} !== {1'b1, 32'h100, 4'b1111})
            $display("FAIL ma_ld_req got req=%b addr=%h be=%b exp 1 100 1111", mem_req, mem_addr, mem_be); else n_pass++;
        mem_gnt = 1'b1;
        @(negedge clk); mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h1122_3344;
        @(negedge clk); mem_rvalid = 1'b0;
        n_total++; if ({ld_resp_valid, ld_resp_err, ld_resp_data, ld_resp_tag} !== {1'b1, 1'b0, 32'h1122_3344, 4'h6})
            $display("FAIL ma_ld_resp got v=%b err=%b d=%h tag=%h exp 1 0 11223344 6", ld_resp_valid, ld_resp_err, ld_resp_data, ld_resp_tag); else n_pass++;
        st_valid = 1'b1; st_addr = 32'h201; st_size = 2'b01; st_data = 32'h0000_BEEF;
        @(negedge clk); st_valid = 1'b0;
        n_total++; if ({mem_req, mem_be, mem_wdata} !== {1'b1, 4'b0110, 32'hBEEF_BEEF})
            $display("FAIL ma_st_req got req=%b be=%b wd=%h exp 1 0110 beefbeef", mem_req, mem_be, mem_wdata); else n_pass++;
        mem_gnt = 1'b1;
        @(negedge clk); mem_gnt = 1'b0;
        n_total++; if ({st_done, st_err} !== 2'b10) $display("FAIL ma_st_done got done=%b err=%b exp 1 0", st_done, st_err); else n_pass++;
`endif
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        ld_valid = 1'b1; ld_addr = 32'h700; ld_size = 3'b010; ld_tag = 4'h1;
        @(negedge clk); ld_valid = 1'b0;
        n_total++; if (mem_req !== 1'b1) $display("FAIL rm_req got %b exp 1", mem_req); else n_pass++;
        rst_n = 1'b0; #1;
        n_total++; if (mem_req !== 1'b0) $display("FAIL rm_req_async got %b exp 0", mem_req); else n_pass++;
        @(negedge clk); rst_n = 1'b1;
        ld_valid = 1'b1; st_valid = 1'b1; st_addr = 32'h800; st_size = 2'b10; #1;
        n_total++; if ({st_ready, ld_ready} !== 2'b10) $display("FAIL rm_idle got st=%b ld=%b exp 1 0", st_ready, ld_ready); else n_pass++;
        ld_valid = 1'b0; st_valid = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_load_byte();
        test_load_half();
        test_store_byte();
        test_starve();
        test_flush_resp();
        test_flush_req();
        test_rvalid_ignored();
        test_misalign();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
